// File: rtl/distance_pkg.sv
`default_nettype none
// ============================================================================
// Module  : distance_pkg
// Brief   : Register map, STATUS bit positions and FSM encoding shared by the
//           ultrasonic distance peripheral.
// Revision: 1.0 - initial release
// ============================================================================
package distance_pkg;

  localparam logic [3:0] c_addr_ctrl   = 4'h0;
  localparam logic [3:0] c_addr_status = 4'h2;
  localparam logic [3:0] c_addr_dist   = 4'h4;

  localparam int c_ctrl_start = 0;
  localparam int c_ctrl_cont  = 1;

  localparam int c_stat_busy    = 0;
  localparam int c_stat_done    = 1;
  localparam int c_stat_timeout = 2;
  localparam int c_stat_cont    = 3;

  localparam logic [15:0] c_dist_timeout = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_HIGH = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/us_timer.sv
`default_nettype none
// ============================================================================
// Module  : us_timer
// Brief   : Microsecond prescaler plus saturating microsecond counter.
// Revision: 1.0 - initial release
// ============================================================================
module us_timer #(
  parameter int TICKS_PER_US = 50,
  parameter int LIMIT        = 30000,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  output logic          tick,
  output logic [CW-1:0] count
);

  localparam int            c_pw       = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [c_pw-1:0] c_pre_last = c_pw'(TICKS_PER_US - 1);
  localparam logic [CW-1:0] c_limit    = CW'(LIMIT);

  logic [c_pw-1:0] r_pre;
  logic [CW-1:0]   r_count;

  // Clearing the prescaler too keeps every interval an exact number of clocks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre   <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_pre   <= '0;
      r_count <= '0;
    end else begin
      r_pre <= (r_pre == c_pre_last) ? '0 : r_pre + c_pw'(1);
      if (tick && (r_count != c_limit)) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign tick  = (r_pre == c_pre_last);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/peripheral_distance.sv
`default_nettype none
// ============================================================================
// Module  : peripheral_distance
// Brief   : CPU-mapped ultrasonic range finder: trigger, echo timing, status.
// Revision: 1.0 - initial release
// ============================================================================
module peripheral_distance
  import distance_pkg::*;
#(
  parameter int TICKS_PER_US = 50,
  parameter int TRIG_US      = 10,
  parameter int TIMEOUT_US   = 30000,
  parameter int HOLDOFF_US   = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  output logic        trig,
  input  logic        echo
);

  localparam int          c_limit        = max3(TRIG_US, TIMEOUT_US, HOLDOFF_US);
  localparam logic [15:0] c_trig_last    = 16'(TRIG_US - 1);
  localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_US - 1);
  localparam logic [15:0] c_holdoff_last = 16'(HOLDOFF_US - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_echo_s1;
  logic        r_echo_s2;
  logic        r_echo_d;
  logic        r_done;
  logic        r_timeout;
  logic        r_cont;
  logic [15:0] r_dist;
  logic [15:0] r_dout;

  logic        w_tick;
  logic        w_clear;
  logic        w_wr;
  logic        w_rd;
  logic        w_start;
  logic        w_rise;
  logic        w_fall;
  logic        w_busy;
  logic        w_finish;
  logic        w_timeout_hit;
  logic [15:0] w_count;
  logic [15:0] w_measured;
  logic [15:0] w_dist_new;
  logic [15:0] w_status;
  logic        w_unused;

  assign w_wr     = cs & wr;
  assign w_rd     = cs & rd;
  assign w_start  = w_wr && (addr == c_addr_ctrl) && d_in[c_ctrl_start];
  assign w_rise   = r_echo_s2 & ~r_echo_d;
  assign w_fall   = ~r_echo_s2 & r_echo_d;
  assign w_busy   = (r_state != ST_IDLE);
  assign w_clear  = (w_state_next != r_state);
  assign w_unused = ^d_in[15:2];

  // The tick landing on the falling-edge cycle completes the last microsecond
  assign w_measured = w_count + {15'b0, w_tick};

  us_timer #(
    .TICKS_PER_US (TICKS_PER_US),
    .LIMIT        (c_limit),
    .CW           (16)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .tick  (w_tick),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_echo_s1 <= 1'b0;
      r_echo_s2 <= 1'b0;
      r_echo_d  <= 1'b0;
    end else begin
      r_echo_s1 <= echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_d  <= r_echo_s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_finish      = 1'b0;
    w_timeout_hit = 1'b0;
    w_dist_new    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_start || r_cont) w_state_next = ST_TRIG;
      end
      ST_TRIG: begin
        if (w_tick && (w_count == c_trig_last)) w_state_next = ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: begin
        if (w_rise) begin
          w_state_next = ST_MEASURE;
        end else if (w_tick && (w_count == c_timeout_last)) begin
          w_finish      = 1'b1;
          w_timeout_hit = 1'b1;
          w_dist_new    = c_dist_timeout;
          w_state_next  = ST_HOLDOFF;
        end
      end
      ST_MEASURE: begin
        // Reaching the limit outranks a coincident falling edge
        if (w_tick && (w_count == c_timeout_last)) begin
          w_finish      = 1'b1;
          w_timeout_hit = 1'b1;
          w_dist_new    = c_dist_timeout;
          w_state_next  = ST_HOLDOFF;
        end else if (w_fall) begin
          w_finish     = 1'b1;
          w_dist_new   = w_measured;
          w_state_next = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (w_tick && (w_count == c_holdoff_last)) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_dist    <= '0;
      r_cont    <= 1'b0;
    end else begin
      if (w_finish) begin
        r_done    <= 1'b1;
        r_timeout <= w_timeout_hit;
        r_dist    <= w_dist_new;
      end else if (w_rd && (addr == c_addr_dist)) begin
        r_done <= 1'b0;
      end
      if (w_wr && (addr == c_addr_ctrl)) r_cont <= d_in[c_ctrl_cont];
    end
  end

  always_comb begin
    w_status                 = '0;
    w_status[c_stat_busy]    = w_busy;
    w_status[c_stat_done]    = r_done;
    w_status[c_stat_timeout] = r_timeout;
    w_status[c_stat_cont]    = r_cont;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= '0;
    end else if (w_rd) begin
      case (addr)
        c_addr_status: r_dout <= w_status;
        c_addr_dist:   r_dout <= w_finish ? w_dist_new : r_dist;
        default:       r_dout <= '0;
      endcase
    end
  end

  assign d_out = r_dout;
  assign trig  = (r_state == ST_TRIG);

endmodule
`default_nettype wire
